// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the dcache memory port and mem_ctrl: a small FIFO of
// evicted blocks that coalesces rewrites, serves refill hits and drains when no read is pending.
module dcache_wb_buffer #(
  parameter int N_ENTRIES        = 4,
  parameter int BLOCK_ADDR_WIDTH = 26,
  parameter int BLOCK_DATA_WIDTH = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          up_req_valid,
  input  logic                          up_req_type,
  input  logic [BLOCK_ADDR_WIDTH-1:0]   up_req_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0]   up_req_block_data,
  output logic                          up_req_ready,
  output logic                          up_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0]   up_resp_block_data,
  output logic                          mem_req_valid,
  output logic                          mem_req_type,
  output logic [BLOCK_ADDR_WIDTH-1:0]   mem_req_block_addr,
  output logic [BLOCK_DATA_WIDTH-1:0]   mem_req_block_data,
  input  logic                          mem_req_ready,
  input  logic                          mem_resp_valid,
  input  logic [BLOCK_DATA_WIDTH-1:0]   mem_resp_block_data,
  output logic [$clog2(N_ENTRIES):0]    count,
  output logic [1:0]                    o_dbg_state
);
  localparam int PW = $clog2(N_ENTRIES);
  localparam int CW = PW + 1;

  // Handshakes: a transfer happens on any cycle where valid and ready are both high;
  // valid never depends on ready, and a refused request may be withdrawn or changed.
  typedef enum logic [1:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_HIT_RESP} state_t;

  state_t                       r_state, w_state_nxt;
  logic [BLOCK_ADDR_WIDTH-1:0]  r_addr [N_ENTRIES];
  logic [BLOCK_DATA_WIDTH-1:0]  r_data [N_ENTRIES];
  logic [PW-1:0]                r_head, r_tail;
  logic [CW-1:0]                r_count;
  logic [BLOCK_ADDR_WIDTH-1:0]  r_rd_addr;
  logic [BLOCK_DATA_WIDTH-1:0]  r_hit_data;

  logic [PW-1:0]        w_off [N_ENTRIES];
  logic [N_ENTRIES-1:0] w_rmatch, w_wmatch;
  logic [PW-1:0]        w_ridx, w_widx;
  logic                 w_rhit, w_whit, w_drain, w_pop;
  logic                 w_acc, w_wr_acc, w_enq, w_rd_acc;

  assign w_drain = (r_state == S_IDLE || r_state == S_HIT_RESP) && (r_count != '0);
  assign w_pop   = !rst && w_drain && mem_req_ready;

  // The head being popped this cycle no longer counts as a write match, so a write
  // to that address becomes a fresh entry behind it.
  always_comb begin
    w_rmatch = '0;
    w_wmatch = '0;
    w_ridx   = '0;
    w_widx   = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      w_off[i]    = PW'(i) - r_head;
      w_rmatch[i] = ({1'b0, w_off[i]} < r_count) && (r_addr[i] == up_req_block_addr);
      w_wmatch[i] = w_rmatch[i] && !(w_pop && (PW'(i) == r_head));
      if (w_rmatch[i]) w_ridx = PW'(i);
      if (w_wmatch[i]) w_widx = PW'(i);
    end
  end

  assign w_rhit = |w_rmatch;
  assign w_whit = |w_wmatch;

  assign up_req_ready = !rst && (up_req_type ? ((r_count < CW'(N_ENTRIES)) || w_whit)
                                             : (r_state == S_IDLE));
  assign w_acc    = up_req_valid && up_req_ready;
  assign w_wr_acc = w_acc && up_req_type;
  assign w_enq    = w_wr_acc && !w_whit;
  assign w_rd_acc = w_acc && !up_req_type;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_rd_acc) w_state_nxt = w_rhit ? S_HIT_RESP : S_RD_REQ;
      S_RD_REQ:   if (mem_req_ready) w_state_nxt = S_RD_WAIT;
      S_RD_WAIT:  if (mem_resp_valid) w_state_nxt = S_IDLE;
      S_HIT_RESP: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= r_count + CW'(w_enq) - CW'(w_pop);
      if (w_pop) r_head <= r_head + 1'b1;
      if (w_enq) begin
        r_addr[r_tail] <= up_req_block_addr;
        r_data[r_tail] <= up_req_block_data;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_wr_acc && w_whit) r_data[w_widx] <= up_req_block_data;
      if (w_rd_acc) begin
        r_rd_addr  <= up_req_block_addr;
        r_hit_data <= r_data[w_ridx];
      end
    end
  end

  // A pending refill read owns the memory port; drains wait until it is issued and answered.
  assign mem_req_valid      = !rst && ((r_state == S_RD_REQ) || w_drain);
  assign mem_req_type       = (r_state != S_RD_REQ);
  assign mem_req_block_addr = (r_state == S_RD_REQ) ? r_rd_addr : r_addr[r_head];
  assign mem_req_block_data = r_data[r_head];

  assign up_resp_valid      = !rst && ((r_state == S_HIT_RESP) ||
                                       ((r_state == S_RD_WAIT) && mem_resp_valid));
  assign up_resp_block_data = (r_state == S_RD_WAIT) ? mem_resp_block_data : r_hit_data;

  assign count       = r_count;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Bench for dcache_wb_buffer: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the buffer and its single outstanding read.
module tb_dcache_wb_buffer;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = $clog2(N) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          up_req_valid, up_req_type, up_req_ready;
  logic [AW-1:0] up_req_block_addr;
  logic [DW-1:0] up_req_block_data;
  logic          up_resp_valid;
  logic [DW-1:0] up_resp_block_data;
  logic          mem_req_valid, mem_req_type, mem_req_ready;
  logic [AW-1:0] mem_req_block_addr;
  logic [DW-1:0] mem_req_block_data;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_block_data;
  logic [CW-1:0] count;
  logic [1:0]    o_dbg_state;

  dcache_wb_buffer #(.N_ENTRIES(N), .BLOCK_ADDR_WIDTH(AW), .BLOCK_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .up_req_valid(up_req_valid), .up_req_type(up_req_type),
    .up_req_block_addr(up_req_block_addr), .up_req_block_data(up_req_block_data),
    .up_req_ready(up_req_ready),
    .up_resp_valid(up_resp_valid), .up_resp_block_data(up_resp_block_data),
    .mem_req_valid(mem_req_valid), .mem_req_type(mem_req_type),
    .mem_req_block_addr(mem_req_block_addr), .mem_req_block_data(mem_req_block_data),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_block_data(mem_resp_block_data),
    .count(count), .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fails  = 0;

  logic [AW-1:0] exp_q[$];      // buffered block addresses, oldest first
  logic [DW-1:0] exp_dq[$];     // matching block data
  logic          m_rd_issue, m_rd_wait, m_hit;
  logic [AW-1:0] m_rd_addr;
  logic [DW-1:0] m_hit_data;

  // what the DUT actually put on the memory port at each handshake
  logic [AW:0]   obs_log[$];
  logic [DW-1:0] obs_dlog[$];
  int            obs_rd_cycles;
  logic          last_ready, last_rv;
  logic [DW-1:0] last_rd;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one cycle with model check ----------------
  task automatic step(input logic r, input logic v, input logic t, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic mrdy, input logic mrv,
                      input logic [DW-1:0] mrd);
    logic idle, drain, pop, exp_ready, exp_mv, exp_rv, acc;
    int coal, hit;
    @(negedge clk);
    rst = r; up_req_valid = v; up_req_type = t; up_req_block_addr = a;
    up_req_block_data = d; mem_req_ready = mrdy; mem_resp_valid = mrv;
    mem_resp_block_data = mrd;
    #1;
    idle  = !(m_rd_issue || m_rd_wait || m_hit);
    drain = (idle || m_hit) && (exp_q.size() > 0);
    pop   = !r && drain && mrdy;
    coal  = -1;
    hit   = -1;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (exp_q[j] == a) begin
        hit = j;
        if (!(j == 0 && pop)) coal = j;
      end
    end
    if (r)      exp_ready = 1'b0;
    else if (t) exp_ready = (exp_q.size() < N) || (coal >= 0);
    else        exp_ready = idle;
    exp_mv = !r && (m_rd_issue || drain);
    exp_rv = !r && (m_hit || (m_rd_wait && mrv));

    check_eq("count", DW'(count), DW'(exp_q.size()));
    check_eq("up_req_ready", DW'(up_req_ready), DW'(exp_ready));
    check_eq("mem_req_valid", DW'(mem_req_valid), DW'(exp_mv));
    if (exp_mv) begin
      check_eq("mem_req_type", DW'(mem_req_type), DW'(!m_rd_issue));
      check_eq("mem_req_addr", DW'(mem_req_block_addr), DW'(m_rd_issue ? m_rd_addr : exp_q[0]));
      if (!m_rd_issue) check_eq("mem_req_data", mem_req_block_data, exp_dq[0]);
    end
    check_eq("up_resp_valid", DW'(up_resp_valid), DW'(exp_rv));
    if (exp_rv) check_eq("up_resp_data", up_resp_block_data, m_hit ? m_hit_data : mrd);

    last_ready = up_req_ready;
    last_rv    = up_resp_valid;
    last_rd    = up_resp_block_data;
    if (mem_req_valid && !mem_req_type) obs_rd_cycles++;
    if (mem_req_valid && mrdy) begin
      obs_log.push_back({mem_req_type, mem_req_block_addr});
      obs_dlog.push_back(mem_req_block_data);
    end
    acc = v && exp_ready;

    @(posedge clk);
    if (r) begin
      exp_q.delete(); exp_dq.delete();
      m_rd_issue = 1'b0; m_rd_wait = 1'b0; m_hit = 1'b0;
    end else begin
      if (m_hit) m_hit = 1'b0;
      if (m_rd_wait && mrv) m_rd_wait = 1'b0;
      if (m_rd_issue && mrdy) begin
        m_rd_issue = 1'b0;
        m_rd_wait  = 1'b1;
      end
      if (acc && !t) begin
        if (hit >= 0) begin
          m_hit      = 1'b1;
          m_hit_data = exp_dq[hit];
        end else begin
          m_rd_issue = 1'b1;
          m_rd_addr  = a;
        end
      end
      if (acc && t && coal >= 0) exp_dq[coal] = d;
      if (pop) begin
        void'(exp_q.pop_front());
        void'(exp_dq.pop_front());
      end
      if (acc && t && coal < 0) begin
        exp_q.push_back(a);
        exp_dq.push_back(d);
      end
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic mrdy);
    step(1'b0, 1'b1, 1'b1, a, d, mrdy, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic mrdy);
    step(1'b0, 1'b1, 1'b0, a, '0, mrdy, 1'b0, '0);
  endtask

  task automatic idle_cycles(input int n, input logic mrdy);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0, '0, mrdy, 1'b0, '0);
  endtask

  task automatic clear_log();
    obs_log.delete();
    obs_dlog.delete();
    obs_rd_cycles = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW:0] e;
    rst = 1'b1; up_req_valid = 1'b0; up_req_type = 1'b0; up_req_block_addr = '0;
    up_req_block_data = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_block_data = '0;
    m_rd_issue = 1'b0; m_rd_wait = 1'b0; m_hit = 1'b0; m_rd_addr = '0; m_hit_data = '0;
    obs_rd_cycles = 0;
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0);

    // single write then drain
    clear_log();
    wr(8'h10, 32'h0000_00D0, 1'b0);
    #2 check_eq("tp1_count_after_write", DW'(count), 1);
    idle_cycles(1, 1'b1);
    #2 check_eq("tp1_count_after_pop", DW'(count), 0);
    check_eq("tp1_drain_log", DW'(obs_log.size()), 1);
    if (obs_log.size() == 1) check_eq("tp1_drain_data", obs_dlog[0], 32'hD0);

    // fill, refuse new address, coalesce existing one
    clear_log();
    for (int i = 1; i <= 4; i++) wr(AW'(i), 32'hA0 + DW'(i), 1'b0);
    #2 check_eq("tp2_full_count", DW'(count), 4);
    wr(8'h05, 32'hBB, 1'b0);
    check_eq("tp2_full_refuse", DW'(last_ready), 0);
    wr(8'h03, 32'h0000_00D9, 1'b0);
    check_eq("tp2_coalesce_accept", DW'(last_ready), 1);
    #2 check_eq("tp2_coalesce_count", DW'(count), 4);
    idle_cycles(5, 1'b1);
    check_eq("tp2_drain_n", DW'(obs_dlog.size()), 4);
    if (obs_dlog.size() == 4) begin
      check_eq("tp2_drain3_addr", DW'(obs_log[2]), DW'({1'b1, 8'h03}));
      check_eq("tp2_drain3_data", obs_dlog[2], 32'hD9);
    end

    // read hit served from the buffer
    clear_log();
    wr(8'h20, 32'h0000_00D1, 1'b0);
    rd(8'h20, 1'b0);
    idle_cycles(1, 1'b0);
    check_eq("tp3_hit_valid", DW'(last_rv), 1);
    check_eq("tp3_hit_data", last_rd, 32'hD1);
    check_eq("tp3_no_mem_read", DW'(obs_rd_cycles), 0);
    idle_cycles(2, 1'b1);

    // read miss bypasses the buffered write
    clear_log();
    wr(8'h20, 32'h0000_00E1, 1'b0);
    rd(8'h30, 1'b0);
    idle_cycles(1, 1'b1);
    idle_cycles(2, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h0000_00D2);
    check_eq("tp4_miss_resp_valid", DW'(last_rv), 1);
    check_eq("tp4_miss_resp_data", last_rd, 32'hD2);
    idle_cycles(2, 1'b1);
    check_eq("tp4_log_n", DW'(obs_log.size()), 2);
    if (obs_log.size() == 2) begin
      check_eq("tp4_first_is_read", DW'(obs_log[0]), DW'({1'b0, 8'h30}));
      check_eq("tp4_then_drain", DW'(obs_log[1]), DW'({1'b1, 8'h20}));
    end

    // full, head popping, write to head address
    clear_log();
    for (int i = 1; i <= 4; i++) wr(8'h40 + AW'(i), 32'hC0 + DW'(i), 1'b0);
    wr(8'h41, 32'h55, 1'b1);
    check_eq("tp5_head_write_refused", DW'(last_ready), 0);
    wr(8'h41, 32'h55, 1'b0);
    check_eq("tp5_head_write_new", DW'(last_ready), 1);
    #2 check_eq("tp5_count", DW'(count), 4);
    idle_cycles(6, 1'b1);
    check_eq("tp5_drain_n", DW'(obs_log.size()), 5);
    if (obs_log.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        e = {1'b1, 8'h41 + AW'(i)};
        check_eq("tp5_order", DW'(obs_log[i]), DW'(e));
      end
      check_eq("tp5_last_addr", DW'(obs_log[4]), DW'({1'b1, 8'h41}));
      check_eq("tp5_last_data", obs_dlog[4], 32'h55);
    end

    // reset while waiting for a refill
    wr(8'h77, 32'h1234, 1'b0);
    rd(8'h60, 1'b0);
    idle_cycles(1, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'hDEAD);
    check_eq("tp6_late_resp_ignored", DW'(last_rv), 0);
    #2 check_eq("tp6_count", DW'(count), 0);
    check_eq("tp6_mem_req_valid", DW'(mem_req_valid), 0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 299) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           AW'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
